prog_timer: RTL and testbench

- Programmable down-count interval timer: WIDTH-bit counter, bit 0 loadable/toggling, upper bits borrow-chained.
- Counter is wrapped with a reload register, a run-control state machine and terminal-count/interrupt logic.
- Sits directly above the synchronous counter cells. It generates their load/clear strobes and consumes their count and carry.
- Feeds the interrupt controller (IRQ) and downstream dividers (TC).

---
 rtl/prog_timer_pkg.sv | 20 ++
 rtl/timer_cnt_bit.sv | 24 ++
 rtl/prog_timer.sv | 121 ++++++++++++
 tb/tb_prog_timer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/prog_timer_pkg.sv
// Shared types and constants for the prog_timer interval timer.
package prog_timer_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_PRE_W = 4;
  // The prescale-select bit sits this many positions below the bus width.
  localparam int PRESCALE_SEL_OFS = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  function automatic int prescale_sel(input int width);
    return width - PRESCALE_SEL_OFS;
  endfunction

endpackage

// File: rtl/timer_cnt_bit.sv
// One bit of the loadable down-counter: load beats clear, clear beats the borrow toggle.
module timer_cnt_bit (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic data,
  input  logic bin,
  input  logic clear,
  output logic q,
  output logic qb,
  output logic bout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= 1'b0;
    else if (load)  q <= data;
    else if (clear) q <= 1'b0;
    else if (bin)   q <= ~q;
  end

  assign qb   = ~q;
  assign bout = bin & ~q;

endmodule

// File: rtl/prog_timer.sv
// Programmable down-count interval timer with reload register, run control and sticky IRQ.
// Optional tick prescaler is built when TIMER_PRESCALE_EN is defined.
//
// state  | meaning
// S_IDLE | stopped, Q holds, waiting for START
// S_LOAD | single cycle, Q <= RELOAD
// S_RUN  | counting effective ticks
// S_HOLD | frozen by STOP, START resumes without reload
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DIN,
  input  logic             WRL,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic             TICK,
  input  logic             ACK,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             RUN,
  output logic             IRQ
);

  if (WIDTH < 2 || WIDTH > 32 || PRE_W < 1 || PRE_W >= WIDTH) begin : g_param_check
    $error("prog_timer: unsupported WIDTH/PRE_W combination");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, load_data, qb_unused;
  logic [WIDTH:0]   borrow;
  logic             eff_tick, run_tick, hit, wr_reload, cnt_load, cnt_clear;

`ifdef TIMER_PRESCALE_EN
  localparam int SEL = prescale_sel(WIDTH);
  logic [PRE_W-1:0] pre_val, pre_cnt;
  logic             wr_pre;

  assign wr_pre    = ~WRL & DIN[SEL];
  assign wr_reload = ~WRL & ~DIN[SEL];
  assign eff_tick  = TICK & (pre_cnt == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pre_val <= '0;
      pre_cnt <= '0;
    end else begin
      if (wr_pre) pre_val <= DIN[PRE_W-1:0];
      if (state == S_LOAD)
        pre_cnt <= pre_val;
      else if (state == S_RUN && !STOP && TICK)
        pre_cnt <= eff_tick ? pre_val : pre_cnt - 1'b1;
    end
  end
`else
  assign wr_reload = ~WRL;
  assign eff_tick  = TICK;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          reload <= '0;
    else if (wr_reload) reload <= DIN;
  end

  // A write landing on a load edge goes straight into the counter.
  assign load_data = wr_reload ? DIN : reload;
  assign run_tick  = (state == S_RUN) & ~STOP & eff_tick;
  assign borrow[0] = run_tick;
  // Borrow out of the top bit means a tick found Q == 0.
  assign hit       = borrow[WIDTH];
  assign cnt_load  = (state == S_LOAD) | (hit & MODE);
  assign cnt_clear = hit & ~MODE;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    timer_cnt_bit u_bit (
      .clk   (CLK),
      .rst   (RESET),
      .load  (cnt_load),
      .data  (load_data[i]),
      .bin   (borrow[i]),
      .clear (cnt_clear),
      .q     (Q[i]),
      .qb    (qb_unused[i]),
      .bout  (borrow[i+1])
    );
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      TC    <= 1'b0;
      IRQ   <= 1'b0;
    end else begin
      state <= state_nxt;
      TC    <= hit;
      IRQ   <= hit | (IRQ & ~ACK);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (START && !STOP) state_nxt = S_LOAD;
      S_LOAD: state_nxt = STOP ? S_HOLD : S_RUN;
      S_RUN: begin
        if (STOP)               state_nxt = S_HOLD;
        else if (hit && !MODE)  state_nxt = S_IDLE;
      end
      S_HOLD: if (START && !STOP) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign RUN = (state == S_LOAD) || (state == S_RUN);

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: driver queues hand-computed expectations, monitor pops and compares.
module tb_prog_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        wrl = 1'b1;
  logic        start = 1'b0, stop = 1'b0, mode = 1'b0, tick = 1'b0, ack = 1'b0;
  logic [15:0] q;
  logic        tc, run, irq;

  int checks = 0;
  int errors = 0;

  logic [18:0] exp_q[$];
  string       nm_q[$];
  event        sample_ev;

  prog_timer #(.WIDTH(16), .PRE_W(4)) dut (
    .CLK(clk), .RESET(rst), .DIN(din), .WRL(wrl), .START(start), .STOP(stop),
    .MODE(mode), .TICK(tick), .ACK(ack), .Q(q), .TC(tc), .RUN(run), .IRQ(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, want);
    end
  endtask

  initial begin : monitor
    logic [18:0] e;
    string       n;
    forever begin
      @(negedge clk or sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        chk(n, "Q",   {16'd0, q},   {16'd0, e[18:3]});
        chk(n, "TC",  {31'd0, tc},  {31'd0, e[2]});
        chk(n, "RUN", {31'd0, run}, {31'd0, e[1]});
        chk(n, "IRQ", {31'd0, irq}, {31'd0, e[0]});
      end
    end
  end

  task automatic cyc(input string nm, input logic [15:0] eq, input logic etc,
                     input logic erun, input logic eirq);
    @(posedge clk);
    exp_q.push_back({eq, etc, erun, eirq});
    nm_q.push_back(nm);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; ack = 1'b0; wrl = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : driver
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cyc("rst_state", 0, 0, 0, 0);

    // one-shot, RELOAD = 3
    wrl = 0; din = 3; cyc("os_wr", 0, 0, 0, 0);
    tick = 1; start = 1; cyc("os_start", 0, 0, 1, 0);
    cyc("os_load", 3, 0, 1, 0);
    cyc("os_q2", 2, 0, 1, 0);
    cyc("os_q1", 1, 0, 1, 0);
    cyc("os_q0", 0, 0, 1, 0);
    cyc("os_tc", 0, 1, 0, 1);
    cyc("os_idle", 0, 0, 0, 1);
    cyc("os_idle2", 0, 0, 0, 1);
    ack = 1; cyc("os_ack", 0, 0, 0, 0);

    // continuous, RELOAD = 2, then write bypass of 5 on the reload edge
    mode = 1; wrl = 0; din = 2; cyc("ct_wr", 0, 0, 0, 0);
    start = 1; cyc("ct_start", 0, 0, 1, 0);
    cyc("ct_load", 2, 0, 1, 0);
    cyc("ct_q1", 1, 0, 1, 0);
    cyc("ct_q0", 0, 0, 1, 0);
    cyc("ct_tc1", 2, 1, 1, 1);
    cyc("ct_q1b", 1, 0, 1, 1);
    cyc("ct_q0b", 0, 0, 1, 1);
    wrl = 0; din = 5; cyc("ct_bypass", 5, 1, 1, 1);
    for (int v = 4; v >= 0; v--) cyc("ct_down", 16'(v), 0, 1, 1);
    ack = 1; cyc("irq_race", 5, 1, 1, 1);
    ack = 1; cyc("irq_ack", 4, 0, 1, 0);
    for (int v = 3; v >= 0; v--) cyc("ct_down2", 16'(v), 0, 1, 0);
    cyc("ct_tc3", 5, 1, 1, 1);

    // asynchronous reset mid-RUN with Q = 5, IRQ = 1
    #2 rst = 1'b1;
    #1 exp_q.push_back({16'd0, 1'b0, 1'b0, 1'b0});
    nm_q.push_back("async_rst");
    ->sample_ev;
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst", 0, 0, 0, 0);

    // STOP / START from RELOAD = 10
    mode = 0; wrl = 0; din = 10; cyc("ss_wr", 0, 0, 0, 0);
    start = 1; cyc("ss_start", 0, 0, 1, 0);
    cyc("ss_load", 10, 0, 1, 0);
    for (int v = 9; v >= 6; v--) cyc("ss_down", 16'(v), 0, 1, 0);
    stop = 1; cyc("ss_stop", 6, 0, 0, 0);
    cyc("ss_hold", 6, 0, 0, 0);
    start = 1; cyc("ss_resume", 6, 0, 1, 0);
    cyc("ss_q5", 5, 0, 1, 0);
    cyc("ss_q4", 4, 0, 1, 0);
    start = 1; cyc("ss_start_run", 3, 0, 1, 0);
    start = 1; stop = 1; cyc("ss_both", 3, 0, 0, 0);
    start = 1; cyc("ss_resume2", 3, 0, 1, 0);
    cyc("ss_q2", 2, 0, 1, 0);
    cyc("ss_q1", 1, 0, 1, 0);
    cyc("ss_q0", 0, 0, 1, 0);
    cyc("ss_tc", 0, 1, 0, 1);
    ack = 1; cyc("ss_ack", 0, 0, 0, 0);

    // STOP during LOAD still transfers RELOAD; write in HOLD leaves Q alone
    wrl = 0; din = 7; start = 1; cyc("ld_start", 0, 0, 1, 0);
    stop = 1; cyc("ld_stop", 7, 0, 0, 0);
    wrl = 0; din = 9; cyc("hold_wr", 7, 0, 0, 0);
    start = 1; cyc("ld_resume", 7, 0, 1, 0);
    cyc("ld_q6", 6, 0, 1, 0);

    // RELOAD = 0 in continuous mode: TC on every tick once Q reaches 0
    mode = 1; wrl = 0; din = 0; cyc("z_wr", 5, 0, 1, 0);
    for (int v = 4; v >= 0; v--) cyc("z_down", 16'(v), 0, 1, 0);
    cyc("z_tc1", 0, 1, 1, 1);
    cyc("z_tc2", 0, 1, 1, 1);
    cyc("z_tc3", 0, 1, 1, 1);

`ifdef TIMER_PRESCALE_EN
    // prescale = 2, RELOAD = 1, continuous
    rst = 1'b1; tick = 0;
    @(negedge clk);
    rst = 1'b0;
    wrl = 0; din = 16'h8002; cyc("ps_wr_pre", 0, 0, 0, 0);
    wrl = 0; din = 16'h0001; cyc("ps_wr_rl", 0, 0, 0, 0);
    tick = 1; start = 1; cyc("ps_start", 0, 0, 1, 0);
    cyc("ps_load", 1, 0, 1, 0);
    cyc("ps_t1", 1, 0, 1, 0);
    cyc("ps_t2", 1, 0, 1, 0);
    cyc("ps_t3", 0, 0, 1, 0);
    cyc("ps_t4", 0, 0, 1, 0);
    cyc("ps_t5", 0, 0, 1, 0);
    cyc("ps_t6", 1, 1, 1, 1);
    cyc("ps_t7", 1, 0, 1, 1);
`endif

    #1;
    chk("drain", "pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
